// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures CPU commit records into a FIFO and drains them
// to a debug host over a valid/ready stream. Also keeps retired-instruction and
// cycle counters, raises an almost-full stall request, counts dropped records
// and tracks the halt -> drain -> done sequence.
//
// Optional build macro TRACE_SKIP_NOP_EN: when defined, captured commits whose
// instruction is the canonical NOP (0x00000013) are counted but not stored.
module commit_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                global_en,
    input  logic                commit,
    input  logic [31:0]         commit_pc,
    input  logic [31:0]         commit_instr,
    input  logic                commit_halt,
    input  logic                commit_reg_we,
    input  logic [4:0]          commit_reg_wa,
    input  logic [31:0]         commit_reg_wd,
    input  logic                commit_dmem_we,
    input  logic [31:0]         commit_dmem_wa,
    input  logic [31:0]         commit_dmem_wd,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [167:0]        trace_data,
    output logic [ADDR_W:0]     trace_count,
    output logic                stall_req,
    output logic                overflow,
    output logic [15:0]         drop_cnt,
    output logic [31:0]         instret,
    output logic [31:0]         cycle_cnt,
    output logic                done
);

    localparam int unsigned REC_W = 168;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [REC_W-1:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic [15:0]         r_drop_cnt;
    logic [31:0]         r_instret;
    logic [31:0]         r_cycle_cnt;
    logic                r_done;

    logic                w_run;
    logic                w_cap;
    logic                w_skip;
    logic                w_want;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [REC_W-1:0]    w_rec;

    // Capture qualification: only while running and enabled
    assign w_run  = (r_state == ST_RUN);
    assign w_cap  = global_en & commit & w_run;

`ifdef TRACE_SKIP_NOP_EN
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // NOP records are filtered out; a halt record is never filtered
    assign w_skip = (commit_instr == NOP_INSTR) & ~commit_halt;
`else
    assign w_skip = 1'b0;
`endif

    assign w_want = w_cap & ~w_skip;
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = trace_valid & trace_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle
    assign w_push = w_want & (~w_full | w_pop);
    assign w_drop = w_want & w_full & ~w_pop;

    // Record layout, MSB first: pc, instr, halt, reg_we, reg_wa, reg_wd, dmem_we, dmem_wa, dmem_wd
    assign w_rec = {commit_pc, commit_instr, commit_halt,
                    commit_reg_we, commit_reg_wa, commit_reg_wd,
                    commit_dmem_we, commit_dmem_wa, commit_dmem_wd};

    // Output decode from registered state
    assign trace_count = r_count;
    assign trace_valid = (r_count != CNT_W'(0));
    assign trace_data  = trace_valid ? r_mem[r_rd_ptr] : REC_W'(0);
    assign stall_req   = (r_count >= CNT_W'(DEPTH - 2));
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;
    assign instret     = r_instret;
    assign cycle_cnt   = r_cycle_cnt;
    assign done        = r_done;

    // FIFO storage; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop tracking: sticky flag plus saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Retired-instruction and enabled-cycle counters, both wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret   <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_instret <= r_instret + 32'd1;
            end
            if (global_en & w_run) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
        end
    end

    // Halt sequencing: RUN -> DRAIN on halt capture, DRAIN -> DONE once empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_cap & commit_halt) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_count == CNT_W'(0)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: table-driven basic stream plus
// hand-written overflow, full push/pop, halt/drain and reset-in-drain sequences.
module tb_commit_trace_buffer;

    localparam logic [31:0] HALT = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h00A0_0093;

    logic         clk = 1'b0;
    logic         rst;
    logic         global_en;
    logic         commit;
    logic [31:0]  commit_pc;
    logic [31:0]  commit_instr;
    logic         commit_halt;
    logic         commit_reg_we;
    logic [4:0]   commit_reg_wa;
    logic [31:0]  commit_reg_wd;
    logic         commit_dmem_we;
    logic [31:0]  commit_dmem_wa;
    logic [31:0]  commit_dmem_wd;
    logic         trace_valid;
    logic         trace_ready;
    logic [167:0] trace_data;
    logic [4:0]   trace_count;
    logic         stall_req;
    logic         overflow;
    logic [15:0]  drop_cnt;
    logic [31:0]  instret;
    logic [31:0]  cycle_cnt;
    logic         done;

    int n_checks = 0;
    int n_err    = 0;

    commit_trace_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .global_en      (global_en),
        .commit         (commit),
        .commit_pc      (commit_pc),
        .commit_instr   (commit_instr),
        .commit_halt    (commit_halt),
        .commit_reg_we  (commit_reg_we),
        .commit_reg_wa  (commit_reg_wa),
        .commit_reg_wd  (commit_reg_wd),
        .commit_dmem_we (commit_dmem_we),
        .commit_dmem_wa (commit_dmem_wa),
        .commit_dmem_wd (commit_dmem_wd),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .stall_req      (stall_req),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .instret        (instret),
        .cycle_cnt      (cycle_cnt),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        commit;
        logic [31:0] pc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [4:0]  exp_count;
        logic [31:0] exp_instret;
        logic [31:0] exp_cycle;
    } vec_t;

    vec_t vecs [4];

    // Expected record for a commit, built in the documented field order
    function automatic logic [167:0] mk_rec(input logic [31:0] pc, input logic [31:0] instr);
        logic h;
        h = (instr == HALT);
        return {pc, instr, h, pc[2], pc[6:2], pc ^ 32'hA5A5_0000,
                pc[3], pc + 32'h0000_1000, ~pc};
    endfunction

    task automatic drive(input logic c, input logic [31:0] pc,
                         input logic [31:0] instr, input logic rdy);
        commit         = c;
        commit_pc      = pc;
        commit_instr   = instr;
        commit_halt    = (instr == HALT);
        commit_reg_we  = pc[2];
        commit_reg_wa  = pc[6:2];
        commit_reg_wd  = pc ^ 32'hA5A5_0000;
        commit_dmem_we = pc[3];
        commit_dmem_wa = pc + 32'h0000_1000;
        commit_dmem_wd = ~pc;
        trace_ready    = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        global_en = 1'b1;

        vecs[0] = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 5'd1, 32'd1, 32'd1};
        vecs[1] = '{1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 5'd1, 32'd2, 32'd2};
        vecs[2] = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 5'd1, 32'd3, 32'd3};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0, 32'd3, 32'd4};

        // Reset state
        do_reset;
        chk("rst_valid",    168'(trace_valid), 168'(0));
        chk("rst_count",    168'(trace_count), 168'(0));
        chk("rst_data",     trace_data, 168'(0));
        chk("rst_stall",    168'(stall_req), 168'(0));
        chk("rst_overflow", 168'(overflow), 168'(0));
        chk("rst_drop",     168'(drop_cnt), 168'(0));
        chk("rst_instret",  168'(instret), 168'(0));
        chk("rst_cycle",    168'(cycle_cnt), 168'(0));
        chk("rst_done",     168'(done), 168'(0));

        // Basic stream, one record in flight at a time
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].commit, vecs[i].pc, ADDI, vecs[i].ready);
            tick;
            chk($sformatf("v%0d_valid", i),   168'(trace_valid), 168'(vecs[i].exp_valid));
            chk($sformatf("v%0d_count", i),   168'(trace_count), 168'(vecs[i].exp_count));
            chk($sformatf("v%0d_instret", i), 168'(instret), 168'(vecs[i].exp_instret));
            chk($sformatf("v%0d_cycle", i),   168'(cycle_cnt), 168'(vecs[i].exp_cycle));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_data", i), trace_data, mk_rec(vecs[i].exp_pc, ADDI));
            end
        end

        // Overflow: 18 commits with host stalled
        do_reset;
        for (int i = 0; i < 18; i++) begin
            int ec;
            drive(1'b1, 32'h100 + 32'(4 * i), ADDI, 1'b0);
            tick;
            ec = (i + 1 > 16) ? 16 : i + 1;
            chk($sformatf("ovf_count_%0d", i), 168'(trace_count), 168'(ec));
            chk($sformatf("ovf_stall_%0d", i), 168'(stall_req), 168'(ec >= 14));
        end
        chk("ovf_flag",    168'(overflow), 168'(1));
        chk("ovf_drop",    168'(drop_cnt), 168'(2));
        chk("ovf_instret", 168'(instret), 168'(18));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovf_drain_valid_%0d", k), 168'(trace_valid), 168'(1));
            chk($sformatf("ovf_drain_data_%0d", k), trace_data, mk_rec(32'h100 + 32'(4 * k), ADDI));
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            tick;
        end
        chk("ovf_empty_valid", 168'(trace_valid), 168'(0));
        chk("ovf_empty_count", 168'(trace_count), 168'(0));
        chk("ovf_sticky",      168'(overflow), 168'(1));

        // Full FIFO with simultaneous push and pop
        do_reset;
        chk("full_rst_overflow", 168'(overflow), 168'(0));
        chk("full_rst_drop",     168'(drop_cnt), 168'(0));
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), ADDI, 1'b0);
            tick;
        end
        chk("full_count", 168'(trace_count), 168'(16));
        drive(1'b1, 32'h300, ADDI, 1'b1);
        tick;
        chk("full_pp_count",    168'(trace_count), 168'(16));
        chk("full_pp_drop",     168'(drop_cnt), 168'(0));
        chk("full_pp_overflow", 168'(overflow), 168'(0));
        chk("full_pp_instret",  168'(instret), 168'(17));
        for (int k = 0; k < 16; k++) begin
            logic [31:0] epc;
            epc = (k < 15) ? 32'h204 + 32'(4 * k) : 32'h300;
            chk($sformatf("full_drain_data_%0d", k), trace_data, mk_rec(epc, ADDI));
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            tick;
        end
        chk("full_drain_count", 168'(trace_count), 168'(0));

        // Halt with two records pending, then ignored commits and drain
        do_reset;
        drive(1'b1, 32'h10, ADDI, 1'b0); tick;
        drive(1'b1, 32'h14, ADDI, 1'b0); tick;
        drive(1'b1, 32'h18, HALT, 1'b0); tick;
        chk("halt_count",   168'(trace_count), 168'(3));
        chk("halt_instret", 168'(instret), 168'(3));
        chk("halt_cycle",   168'(cycle_cnt), 168'(3));
        chk("halt_done0",   168'(done), 168'(0));
        drive(1'b1, 32'h1c, ADDI, 1'b0); tick;
        drive(1'b1, 32'h20, ADDI, 1'b0); tick;
        chk("drain_ign_count",   168'(trace_count), 168'(3));
        chk("drain_ign_instret", 168'(instret), 168'(3));
        chk("drain_ign_cycle",   168'(cycle_cnt), 168'(3));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("halt_drain_data_%0d", k), trace_data,
                mk_rec(32'h10 + 32'(4 * k), (k == 2) ? HALT : ADDI));
            drive(1'b1, 32'h24 + 32'(4 * k), ADDI, 1'b1);
            tick;
        end
        chk("halt_empty_count", 168'(trace_count), 168'(0));
        chk("halt_done_early",  168'(done), 168'(0));
        drive(1'b1, 32'h40, ADDI, 1'b1);
        tick;
        chk("halt_done",        168'(done), 168'(1));
        chk("halt_done_valid",  168'(trace_valid), 168'(0));
        chk("halt_done_instret", 168'(instret), 168'(3));
        tick;
        chk("halt_done_hold",   168'(done), 168'(1));
        chk("halt_done_count",  168'(trace_count), 168'(0));

        // Reset while draining with five records pending
        do_reset;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h80 + 32'(4 * i), ADDI, 1'b0);
            tick;
        end
        drive(1'b1, 32'h90, HALT, 1'b0);
        tick;
        chk("rd_count5", 168'(trace_count), 168'(5));
        rst = 1'b1;
        drive(1'b1, 32'h40, ADDI, 1'b0);
        tick;
        chk("rd_count",    168'(trace_count), 168'(0));
        chk("rd_valid",    168'(trace_valid), 168'(0));
        chk("rd_done",     168'(done), 168'(0));
        chk("rd_overflow", 168'(overflow), 168'(0));
        chk("rd_instret",  168'(instret), 168'(0));
        rst = 1'b0;
        drive(1'b1, 32'h40, ADDI, 1'b0);
        tick;
        chk("rd_resume_count",   168'(trace_count), 168'(1));
        chk("rd_resume_instret", 168'(instret), 168'(1));
        chk("rd_resume_data",    trace_data, mk_rec(32'h40, ADDI));

        // NOP filtering
        do_reset;
        drive(1'b1, 32'h50, NOP, 1'b0); tick;
        drive(1'b1, 32'h54, 32'h0050_0093, 1'b0); tick;
        chk("nop_instret", 168'(instret), 168'(2));
`ifdef TRACE_SKIP_NOP_EN
        chk("nop_count",    168'(trace_count), 168'(1));
        chk("nop_data",     trace_data, mk_rec(32'h54, 32'h0050_0093));
        chk("nop_overflow", 168'(overflow), 168'(0));
`else
        chk("nop_count",    168'(trace_count), 168'(2));
        chk("nop_data",     trace_data, mk_rec(32'h50, NOP));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the pipelined CPU's commit/debug interface.
- Captures each retired instruction's commit record (PC, instruction, register write, data-memory write) into a FIFO.
- Drains records to a debug host over a valid/ready stream.
- Keeps retired-instruction and cycle counters, requests a CPU stall when nearly full, and tracks the halt → drain → done sequence.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 4.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- global_en  input  1  CPU global enable; captures and cycle counting qualified by it
- commit  input  1  CPU commit strobe
- commit_pc  input  32  retired PC
- commit_instr  input  32  retired instruction
- commit_halt  input  1  retired instruction is halt (0x00100073)
- commit_reg_we  input  1  register-file write enable
- commit_reg_wa  input  5  register write address
- commit_reg_wd  input  32  register write data
- commit_dmem_we  input  1  data-memory write enable
- commit_dmem_wa  input  32  data-memory write address (word aligned)
- commit_dmem_wd  input  32  data-memory write data
- trace_valid  output  1  head record available
- trace_ready  input  1  host accepts head record
- trace_data  output  168  head record; packed MSB→LSB: pc[31:0], instr[31:0], halt, reg_we, reg_wa[4:0], reg_wd[31:0], dmem_we, dmem_wa[31:0], dmem_wd[31:0]
- trace_count  output  ADDR_W+1  entries currently held
- stall_req  output  1  almost-full; top level gates global_en with it
- overflow  output  1  sticky: at least one record dropped
- drop_cnt  output  16  dropped records, saturating at 0xFFFF
- instret  output  32  accepted commits, wraps
- cycle_cnt  output  32  enabled cycles in RUN, wraps
- done  output  1  halt seen and FIFO fully drained

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, state RUN. Reset mid-drain discards all contents.
- cap = global_en & commit & (state==RUN).
- pop = trace_valid & trace_ready.
- trace_valid = (trace_count != 0).
- trace_data is the registered head entry and stays stable while trace_valid & !trace_ready.
- Latency: record captured at edge N is visible on trace_valid/trace_data after edge N (one cycle), if the FIFO was empty.
- Push: when cap & (count < DEPTH, or pop in the same cycle), write at wr_ptr; wr_ptr wraps modulo DEPTH.
- Full and no pop: record dropped; overflow set; drop_cnt incremented (saturating); instret still counts.
- Simultaneous push/pop: count unchanged. Valid when empty only in the sense that the pushed entry appears next cycle; no bypass.
- instret increments on every cap, including dropped and filtered records.
- cycle_cnt increments each cycle with global_en & state==RUN.
- stall_req = (trace_count >= DEPTH-2), decoded combinationally from the count register.
- State machine:
  - RUN → DRAIN on cap & commit_halt; the halt record itself is pushed (or dropped if full).
  - DRAIN: no captures; commits are ignored and not counted.
  - DRAIN → DONE when trace_count == 0 at the clock edge.
  - DONE: done=1; holds until rst; pops on an empty FIFO are ignored.
- Widths: trace_count is ADDR_W+1 bits, range 0..DEPTH; the counters wrap at 2^32.

Optional Feature:
- Macro: TRACE_SKIP_NOP_EN.
- Defined: a capture with commit_instr == 0x00000013 is not pushed and never triggers overflow; instret still increments. A halt record is always pushed.
- Undefined: every capture is pushed as described above.

Test Plan:
- Reset then 3 commits (pc 0x0, 0x4, 0x8), trace_ready=1 → trace_valid one cycle after each; trace_data pc fields 0x0, 0x4, 0x8 in order; instret=3.
- trace_ready=0, 18 consecutive commits, DEPTH=16:
  - stall_req rises at count=14.
  - count saturates at 16.
  - overflow=1, drop_cnt=2, instret=18.
  - After draining, exactly 16 records in order, first pc = the first commit's pc.
- FIFO full (16), commit and pop in the same cycle → count stays 16, no drop, new record at the tail.
- Halt commit (instr 0x00100073) with 2 entries pending, then further commits → halt record is last out; later commits ignored; instret frozen; done=1 one cycle after count reaches 0.
- rst asserted in DRAIN with 5 entries pending → next cycle count=0, done=0, overflow=0, state RUN, captures resume.
- With TRACE_SKIP_NOP_EN: commits 0x00000013, 0x00500093 → one record (0x00500093), instret=2; without the macro, two records.
